huffman_freq_accum: RTL and testbench

Parametrised symbol-frequency accumulator that feeds the Huffman tree builder. It sits on the AHB-lite-style slave write path and accepts a byte length, a start command and packed data words. For every data word it counts up to LANES symbols per cycle into NUM_SYM saturating bins. It then presents the histogram, the distinct-symbol count and a done flag for tree construction.

---
 rtl/huffman_freq_accum_if.sv | 14 +
 rtl/huffman_freq_accum.sv | 193 +++++++++++++++++++
 tb/tb_huffman_freq_accum.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_freq_accum_if.sv
// Write-only slave bus carrying address, data, strobe and size, with a registered
// error response back to the master.
interface huffman_freq_accum_if #(
  parameter int unsigned DATA_W = 32
);
  logic [31:0]       HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic              HRESP;

  modport master (output HADDR, HWDATA, HWRITE, HSIZE, input HRESP);
  modport slave  (input HADDR, HWDATA, HWRITE, HSIZE, output HRESP);
endinterface

// File: rtl/huffman_freq_accum.sv
// Symbol-frequency accumulator feeding the Huffman tree builder: counts up to LANES
// symbols per written word into saturating bins and reports the histogram when done.
module huffman_freq_accum #(
  parameter int unsigned SYM_W     = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned BASE_ADDR = 1000
) (
  input  logic                              clk,
  input  logic                              reset,
  huffman_freq_accum_if.slave               bus,
  input  logic                              clear,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow,
  output logic [LEN_W-1:0]                  count_size,
  output logic [SYM_W:0]                    nonzero_syms,
  output logic [(2**SYM_W)*CNT_W-1:0]       counts
);

  localparam int unsigned NUM_SYM = 2 ** SYM_W;
  localparam int unsigned LANES   = DATA_W / SYM_W;
  localparam int unsigned INC_W   = $clog2(LANES + 1);
  localparam int unsigned SUM_W   = CNT_W + INC_W;
  localparam int unsigned NZ_W    = SYM_W + 1;

  localparam logic [31:0]      ADDR_CTRL = 32'(BASE_ADDR + 1);
  localparam logic [31:0]      ADDR_LEN  = 32'(BASE_ADDR + 2);
  localparam logic [31:0]      ADDR_DATA = 32'(BASE_ADDR + 3);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] bin_q [NUM_SYM];
  logic [CNT_W-1:0] bin_d [NUM_SYM];
  logic [CNT_W-1:0] bin_nxt [NUM_SYM];
  logic [SUM_W-1:0] bin_sum [NUM_SYM];
  logic [INC_W-1:0] inc [NUM_SYM];

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] count_size_q, count_size_d;
  logic [NZ_W-1:0]  nonzero_q, nonzero_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hresp_q, hresp_d;

  logic             wr_ctrl, wr_len, wr_data;
  logic             start_fire, len_fire, data_fire, err;
  logic [INC_W-1:0] take_n;
  logic [SYM_W-1:0] lane_sym [LANES];
  logic             lane_vld [LANES];
  logic [NZ_W-1:0]  nz_new;
  logic             clip;

  // Write decode; clear suppresses every write, including its error response
  always_comb begin
    wr_ctrl    = bus.HWRITE && (bus.HADDR == ADDR_CTRL);
    wr_len     = bus.HWRITE && (bus.HADDR == ADDR_LEN);
    wr_data    = bus.HWRITE && (bus.HADDR == ADDR_DATA);
    start_fire = !clear && wr_ctrl && bus.HWDATA[0] && (state_q != S_ACCUM);
    len_fire   = !clear && wr_len && (state_q != S_ACCUM);
    data_fire  = !clear && wr_data && (state_q == S_ACCUM) && (bus.HSIZE == 3'd2);
    err        = !clear &&
                 ((wr_data && !((state_q == S_ACCUM) && (bus.HSIZE == 3'd2))) ||
                  ((state_q == S_ACCUM) && ((wr_ctrl && bus.HWDATA[0]) || wr_len)));
  end

  // Only the first min(LANES, remaining) lanes of a word take part
  always_comb begin
    take_n = (remaining_q >= LEN_W'(LANES)) ? INC_W'(LANES) : INC_W'(remaining_q);
    for (int k = 0; k < LANES; k++) begin
      lane_sym[k] = bus.HWDATA[k*SYM_W +: SYM_W];
      lane_vld[k] = LEN_W'(k) < remaining_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SYM; i++) inc[i] = '0;
    for (int i = 0; i < NUM_SYM; i++) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_vld[k] && (lane_sym[k] == SYM_W'(i))) inc[i] = inc[i] + INC_W'(1);
      end
    end
  end

  // Saturating add per bin, plus the count of bins leaving zero this word
  always_comb begin
    nz_new = '0;
    clip   = 1'b0;
    for (int i = 0; i < NUM_SYM; i++) begin
      bin_sum[i] = SUM_W'(bin_q[i]) + SUM_W'(inc[i]);
      if (bin_sum[i] > SUM_W'(CNT_MAX)) begin
        bin_nxt[i] = CNT_MAX;
        clip       = 1'b1;
      end else begin
        bin_nxt[i] = bin_sum[i][CNT_W-1:0];
      end
      if ((bin_q[i] == '0) && (inc[i] != '0)) nz_new = nz_new + NZ_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (start_fire) begin
      state_d = (len_q == '0) ? S_DONE : S_ACCUM;
    end else if (data_fire && (remaining_q == LEN_W'(take_n))) begin
      state_d = S_DONE;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SYM; i++) bin_d[i] = bin_q[i];
    len_d        = len_q;
    remaining_d  = remaining_q;
    count_size_d = count_size_q;
    nonzero_d    = nonzero_q;
    overflow_d   = overflow_q;
    hresp_d      = err;
    busy_d       = (state_d == S_ACCUM);
    done_d       = (state_d == S_DONE);
    if (clear) begin
      for (int i = 0; i < NUM_SYM; i++) bin_d[i] = '0;
      len_d        = '0;
      remaining_d  = '0;
      count_size_d = '0;
      nonzero_d    = '0;
      overflow_d   = 1'b0;
    end else if (start_fire) begin
      for (int i = 0; i < NUM_SYM; i++) bin_d[i] = '0;
      remaining_d  = len_q;
      count_size_d = '0;
      nonzero_d    = '0;
      overflow_d   = 1'b0;
    end else begin
      if (len_fire) len_d = LEN_W'(bus.HWDATA);
      if (data_fire) begin
        for (int i = 0; i < NUM_SYM; i++) bin_d[i] = bin_nxt[i];
        remaining_d  = remaining_q - LEN_W'(take_n);
        count_size_d = count_size_q + LEN_W'(take_n);
        nonzero_d    = nonzero_q + nz_new;
        overflow_d   = overflow_q | clip;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SYM; i++) bin_q[i] <= '0;
      len_q        <= '0;
      remaining_q  <= '0;
      count_size_q <= '0;
      nonzero_q    <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hresp_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SYM; i++) bin_q[i] <= bin_d[i];
      len_q        <= len_d;
      remaining_q  <= remaining_d;
      count_size_q <= count_size_d;
      nonzero_q    <= nonzero_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hresp_q      <= hresp_d;
    end
  end

  for (genvar i = 0; i < NUM_SYM; i++) begin : g_counts
    assign counts[i*CNT_W +: CNT_W] = bin_q[i];
  end

  assign bus.HRESP    = hresp_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = overflow_q;
  assign count_size   = count_size_q;
  assign nonzero_syms = nonzero_q;

endmodule

// File: tb/tb_huffman_freq_accum.sv
// Directed bench for huffman_freq_accum: a default instance plus a 4-bit-bin instance
// for saturation, with hand-computed expectations.
module tb_huffman_freq_accum;

  localparam int unsigned A_CTRL = 1001;
  localparam int unsigned A_LEN  = 1002;
  localparam int unsigned A_DATA = 1003;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear_a = 1'b0;
  logic clear_b = 1'b0;

  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [15:0] cs_a, cs_b;
  logic [8:0]  nz_a, nz_b;
  logic [256*16-1:0] counts_a;
  logic [256*4-1:0]  counts_b;

  int n_checks = 0;
  int n_fail   = 0;

  huffman_freq_accum_if #(.DATA_W(32)) bus_a ();
  huffman_freq_accum_if #(.DATA_W(32)) bus_b ();

  huffman_freq_accum u_dut (
    .clk(clk), .reset(reset), .bus(bus_a), .clear(clear_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a),
    .count_size(cs_a), .nonzero_syms(nz_a), .counts(counts_a)
  );

  huffman_freq_accum #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus_b), .clear(clear_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b),
    .count_size(cs_b), .nonzero_syms(nz_b), .counts(counts_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cnt_a(input int i);
    return counts_a[i*16 +: 16];
  endfunction

  function automatic logic [3:0] cnt_b(input int i);
    return counts_b[i*4 +: 4];
  endfunction

  task automatic wr(input bit sel, input int unsigned addr, input logic [31:0] data,
                    input logic [2:0] size = 3'd2);
    if (!sel) begin
      bus_a.HADDR = addr; bus_a.HWDATA = data; bus_a.HSIZE = size; bus_a.HWRITE = 1'b1;
    end else begin
      bus_b.HADDR = addr; bus_b.HWDATA = data; bus_b.HSIZE = size; bus_b.HWRITE = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus_a.HWRITE = 1'b0;
    bus_b.HWRITE = 1'b0;
    clear_a = 1'b0;
    clear_b = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] other_or;
    bus_a.HADDR = '0; bus_a.HWDATA = '0; bus_a.HSIZE = 3'd2; bus_a.HWRITE = 1'b0;
    bus_b.HADDR = '0; bus_b.HWDATA = '0; bus_b.HSIZE = 3'd2; bus_b.HWRITE = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(1);

    check("rst_hresp", bus_a.HRESP, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_cs", cs_a, 0);
    check("rst_nz", nz_a, 0);
    check("rst_counts", |counts_a, 0);

    // Four distinct symbols in one word
    wr(0, A_LEN, 32'd4);
    wr(0, A_CTRL, 32'd1);
    check("t1_busy", busy_a, 1);
    check("t1_done_pre", done_a, 0);
    wr(0, A_DATA, 32'h0C14_0003);
    check("t1_c3", cnt_a(3), 1);
    check("t1_c0", cnt_a(0), 1);
    check("t1_c20", cnt_a(20), 1);
    check("t1_c12", cnt_a(12), 1);
    check("t1_c5", cnt_a(5), 0);
    check("t1_nz", nz_a, 4);
    check("t1_cs", cs_a, 4);
    check("t1_done", done_a, 1);
    check("t1_busy_post", busy_a, 0);
    idle(1);

    // Restart from DONE, all lanes identical
    wr(0, A_LEN, 32'd4);
    wr(0, A_CTRL, 32'd1);
    wr(0, A_DATA, 32'h7F7F_7F7F);
    check("t2_c127", cnt_a(127), 4);
    other_or = '0;
    for (int i = 0; i < 256; i++) if (i != 127) other_or |= cnt_a(i);
    check("t2_others", other_or, 0);
    check("t2_nz", nz_a, 1);
    idle(1);

    // Partial last word, then an extra word after completion
    wr(0, A_LEN, 32'd6);
    wr(0, A_CTRL, 32'd1);
    wr(0, A_DATA, 32'h0101_0101);
    check("t3_c1_mid", cnt_a(1), 4);
    check("t3_cs_mid", cs_a, 4);
    check("t3_done_mid", done_a, 0);
    wr(0, A_DATA, 32'h0202_0202);
    check("t3_c1", cnt_a(1), 4);
    check("t3_c2", cnt_a(2), 2);
    check("t3_cs", cs_a, 6);
    check("t3_done", done_a, 1);
    check("t3_nz", nz_a, 2);
    wr(0, A_DATA, 32'h0202_0202);
    check("t3_hresp", bus_a.HRESP, 1);
    check("t3_c2_hold", cnt_a(2), 2);
    check("t3_cs_hold", cs_a, 6);
    idle(1);
    check("t3_hresp_low", bus_a.HRESP, 0);

    // Saturation on the 4-bit-bin instance
    wr(1, A_LEN, 32'd20);
    wr(1, A_CTRL, 32'd1);
    wr(1, A_DATA, 32'h0505_0505);
    wr(1, A_DATA, 32'h0505_0505);
    wr(1, A_DATA, 32'h0505_0505);
    check("t4_c5_12", cnt_b(5), 12);
    check("t4_ovf_pre", ovf_b, 0);
    wr(1, A_DATA, 32'h0505_0505);
    check("t4_c5_sat", cnt_b(5), 15);
    check("t4_ovf", ovf_b, 1);
    check("t4_done_pre", done_b, 0);
    wr(1, A_DATA, 32'h0505_0505);
    check("t4_c5", cnt_b(5), 15);
    check("t4_ovf_post", ovf_b, 1);
    check("t4_done", done_b, 1);
    check("t4_cs", cs_b, 20);
    idle(1);

    // Error responses
    clear_a = 1'b1;
    @(posedge clk);
    #1;
    check("t5_clr_done", done_a, 0);
    check("t5_clr_c1", cnt_a(1), 0);
    idle(1);
    wr(0, A_DATA, 32'h0303_0303);
    check("t5_e1_hresp", bus_a.HRESP, 1);
    check("t5_e1_busy", busy_a, 0);
    check("t5_e1_c3", cnt_a(3), 0);
    idle(1);
    check("t5_e1_low", bus_a.HRESP, 0);
    wr(0, A_LEN, 32'd8);
    wr(0, A_CTRL, 32'd1);
    wr(0, A_DATA, 32'h0303_0303);
    check("t5_c3", cnt_a(3), 4);
    wr(0, A_CTRL, 32'd1);
    check("t5_e2_hresp", bus_a.HRESP, 1);
    check("t5_e2_busy", busy_a, 1);
    check("t5_e2_cs", cs_a, 4);
    check("t5_e2_c3", cnt_a(3), 4);
    idle(1);
    check("t5_e2_low", bus_a.HRESP, 0);
    wr(0, A_DATA, 32'h0303_0303, 3'd0);
    check("t5_e3_hresp", bus_a.HRESP, 1);
    check("t5_e3_c3", cnt_a(3), 4);
    check("t5_e3_cs", cs_a, 4);
    idle(1);
    check("t5_e3_low", bus_a.HRESP, 0);
    wr(0, A_LEN, 32'd1);
    check("t5_e4_hresp", bus_a.HRESP, 1);
    wr(0, A_DATA, 32'h0303_0303);
    check("t5_c3_end", cnt_a(3), 8);
    check("t5_cs_end", cs_a, 8);
    check("t5_done_end", done_a, 1);
    idle(1);

    // Asynchronous reset mid-run
    wr(0, A_LEN, 32'd12);
    wr(0, A_CTRL, 32'd1);
    wr(0, A_DATA, 32'h0102_0304);
    check("t6_c4", cnt_a(4), 1);
    bus_a.HWRITE = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t6_rst_busy", busy_a, 0);
    check("t6_rst_cs", cs_a, 0);
    check("t6_rst_nz", nz_a, 0);
    check("t6_rst_counts", |counts_a, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Clear overriding a simultaneous data write
    wr(0, A_LEN, 32'd12);
    wr(0, A_CTRL, 32'd1);
    wr(0, A_DATA, 32'h0102_0304);
    check("t6_cs_pre", cs_a, 4);
    bus_a.HWDATA = 32'h0505_0505;
    clear_a = 1'b1;
    @(posedge clk);
    #1;
    check("t6_clr_busy", busy_a, 0);
    check("t6_clr_done", done_a, 0);
    check("t6_clr_cs", cs_a, 0);
    check("t6_clr_nz", nz_a, 0);
    check("t6_clr_counts", |counts_a, 0);
    check("t6_clr_hresp", bus_a.HRESP, 0);
    idle(1);
    // Length was cleared too, so a bare start finishes immediately
    wr(0, A_CTRL, 32'd1);
    check("t6_zero_done", done_a, 1);
    check("t6_zero_busy", busy_a, 0);
    check("t6_zero_cs", cs_a, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
